ub_dma_mover: RTL and testbench
===============================

// Module: ub_dma_mover
// PURPOSE
//  Initiator/driver for the Unified Buffer DMA port: moves bursts between host-side valid/ready streams
//  and the UB global address space. LOAD streams host words into UB writes; STORE issues UB reads and
//  streams the returned words to the host with backpressure. Sits between the host interface and the UB.
// PARAMETERS
//  DATA_W      DATA_WIDTH  word width (package constant)
//  ADDR_W      ADDR_WIDTH  UB global address width (package constant)
//  LEN_W       16          burst length counter width (words)
//  RD_LAT      1           UB read latency, cycles from ub_read_en to valid ub_rdata
//  FIFO_DEPTH  4           store-path return FIFO depth; must be >= RD_LAT+1, power of two
// PORTS
//  clk         in   1       single clock
//  reset       in   1       asynchronous, active-high reset
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       command accepted when valid&&ready
//  cmd_dir     in   1       0 = LOAD (host->UB), 1 = STORE (UB->host)
//  cmd_addr    in   ADDR_W  UB start address
//  cmd_len     in   LEN_W   burst length in words; 0 legal
//  in_valid    in   1       LOAD data offered
//  in_ready    out  1       LOAD data accepted
//  in_data     in   DATA_W  LOAD data
//  out_valid   out  1       STORE data offered
//  out_ready   in   1       host accepts STORE data
//  out_data    out  DATA_W  STORE data
//  ub_write_en out  1       to UB dma_write_en
//  ub_read_en  out  1       to UB dma_read_en
//  ub_addr     out  ADDR_W  to UB dma_addr
//  ub_wdata    out  DATA_W  to UB dma_data_in
//  ub_rdata    in   DATA_W  from UB dma_data_out
//  busy        out  1       high whenever state != IDLE
//  done        out  1       one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; cmd_ready=1; ub_write_en=ub_read_en=0; ub_addr=0; ub_wdata=0;
//   in_ready=0; out_valid=0; busy=0; done=0; counters cleared; FIFO and read-valid pipe flushed.
//  FSM: IDLE -> LOAD | STORE | DONE; LOAD -> DONE; STORE -> DRAIN -> DONE; DONE -> IDLE (one cycle).
//   cmd_ready = (state==IDLE). Accept latches addr, len, dir. len==0 -> DONE directly, no UB access.
//  LOAD: in_ready = (state==LOAD && remaining!=0). Handshake at cycle t -> registered ub_write_en=1,
//   ub_addr=cur_addr, ub_wdata=in_data at t+1; cur_addr++, remaining--. Last handshake -> DONE, so
//   done is high in the same cycle as the final write strobe.
//  STORE: issue ub_read_en=1 (registered, addr=cur_addr) when remaining!=0 and
//   fifo_count + inflight < FIFO_DEPTH; inflight counts issued reads not yet returned.
//   ub_rdata is captured into the FIFO RD_LAT cycles after each ub_read_en, via a RD_LAT-deep valid pipe.
//   Last read issued -> DRAIN. DRAIN -> DONE when inflight==0 and FIFO empty and no pop pending.
//  Output stream: out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&&out_ready.
//   Push and pop in the same cycle are both honoured. The credit rule guarantees no overflow.
//   out_data holds stable while out_valid && !out_ready.
//  Address arithmetic: cur_addr increments modulo 2^ADDR_W; wrap is silent, not an error.
//  ub_write_en and ub_read_en are never high in the same cycle. Both are 0 outside LOAD/STORE.
//  done: one-cycle pulse in DONE. cmd_ready is 0 in DONE; the next command is accepted the cycle after.
//  No abort input; reset is the only way to cancel a burst.
// STRUCTURE
//  Shared package: dma_dir_e {DMA_LOAD, DMA_STORE}; dma_state_e {IDLE, LOAD, STORE, DRAIN, DONE};
//   DATA_WIDTH and ADDR_WIDTH from the existing memory package.
//  Sub-module: ub_dma_rfifo (parameterised sync FIFO: DATA_W, FIFO_DEPTH; push, pop, count, async reset).
// TESTING
//  LOAD addr=0x010 len=4, in_valid always high, data A0..A3 -> writes to 0x010..0x013 on consecutive
//   cycles; done pulses with the 4th write; busy low the cycle after.
//  STORE addr=0x010 len=4, out_ready=1, behavioural UB model with RD_LAT=1 -> out_data A0..A3 in order;
//   max 1 idle cycle between issue and first out_valid.
//  STORE len=8, out_ready low for cycles 3-10 -> reads stall once FIFO_DEPTH words are held or in flight;
//   no word is lost or duplicated; 8 words delivered; done only after the last pop.
//  Wrap: LOAD addr=2^ADDR_W-2 len=4 -> writes at max-1, max, 0, 1.
//  len=0 command -> done pulse 1 cycle after accept; no ub_write_en/ub_read_en ever asserted.
//  Reset asserted mid-STORE (2 reads in flight) -> all outputs at reset values immediately;
//   next STORE len=2 returns only its own 2 words.

Source files
------------

// File: rtl/ub_dma_mover_pkg.sv
// Shared types and sizing for the Unified Buffer DMA mover.
// DATA_WIDTH/ADDR_WIDTH mirror the UB memory geometry.
package ub_dma_mover_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 10;
  localparam int LEN_WIDTH   = 16;
  localparam int RD_LATENCY  = 1;
  localparam int RFIFO_DEPTH = 4;

  typedef enum logic {
    DMA_LOAD  = 1'b0,
    DMA_STORE = 1'b1
  } dma_dir_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } dma_state_e;

  // UB addresses wrap silently at the top of the space.
  function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ub_dma_mover_if.sv
// Host command/data streams plus the UB DMA port; slave = the mover, master = host/UB side.
interface ub_dma_mover_if
  import ub_dma_mover_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int LEN_W  = LEN_WIDTH
);

  logic              cmd_valid;
  logic              cmd_ready;
  dma_dir_e          cmd_dir;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic              ub_write_en;
  logic              ub_read_en;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_wdata;
  logic [DATA_W-1:0] ub_rdata;

  modport master (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len,
    output in_valid, in_data, out_ready, ub_rdata,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  ub_write_en, ub_read_en, ub_addr, ub_wdata
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
    input  in_valid, in_data, out_ready, ub_rdata,
    output cmd_ready, in_ready, out_valid, out_data,
    output ub_write_en, ub_read_en, ub_addr, ub_wdata
  );

endinterface

// File: rtl/ub_dma_rfifo.sv
// Store-path return FIFO: zero-latency head, push and pop honoured in the same cycle.
// DEPTH must be a power of two; pushes into a full FIFO without a pop are dropped.
module ub_dma_rfifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_dat_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/ub_dma_mover.sv
// Moves bursts between host valid/ready streams and the UB DMA port (LOAD: host->UB, STORE: UB->host).
// UB strobes are registered one cycle after the decision; STORE reads are credit-limited by the return FIFO.
module ub_dma_mover
  import ub_dma_mover_pkg::*;
#(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int LEN_W      = LEN_WIDTH,
  parameter int RD_LAT     = RD_LATENCY,
  parameter int FIFO_DEPTH = RFIFO_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ub_dma_mover_if.slave  bus,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              ub_we_q, ub_we_d;
  logic              ub_re_q, ub_re_d;
  logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
  logic [DATA_W-1:0] ub_wdata_q, ub_wdata_d;
  logic [RD_LAT-1:0] rd_vld_q;
  logic [RD_LAT:0]   rd_vld_chain;

  logic              wr_hs;
  logic              rd_issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W:0]    credit_used;

  assign wr_hs       = (state_q == LOAD) && (rem_q != '0) && bus.in_valid;
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  // Reads already decided but not yet returned hold a FIFO slot, so the FIFO can never overflow.
  assign rd_issue    = (state_q == STORE) && (rem_q != '0) &&
                       (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign rd_vld_chain = {rd_vld_q, ub_re_q};
  assign push        = rd_vld_q[RD_LAT-1];
  assign pop         = !fifo_empty && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    ub_we_d    = 1'b0;
    ub_re_d    = 1'b0;
    ub_addr_d  = ub_addr_q;
    ub_wdata_d = ub_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          rem_d  = bus.cmd_len;
          if (bus.cmd_len == '0)              state_d = DONE;
          else if (bus.cmd_dir == DMA_STORE)  state_d = STORE;
          else                                state_d = LOAD;
        end
      end
      LOAD: begin
        if (wr_hs) begin
          ub_we_d    = 1'b1;
          ub_addr_d  = addr_q;
          ub_wdata_d = bus.in_data;
          addr_d     = addr_next(addr_q);
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      STORE: begin
        if (rd_issue) begin
          ub_re_d   = 1'b1;
          ub_addr_d = addr_q;
          addr_d    = addr_next(addr_q);
          rem_d     = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && (fifo_count == '0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({rd_issue, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      ub_we_q    <= 1'b0;
      ub_re_q    <= 1'b0;
      ub_addr_q  <= '0;
      ub_wdata_q <= '0;
      rd_vld_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      ub_we_q    <= ub_we_d;
      ub_re_q    <= ub_re_d;
      ub_addr_q  <= ub_addr_d;
      ub_wdata_q <= ub_wdata_d;
      rd_vld_q   <= rd_vld_chain[RD_LAT-1:0];
    end
  end

  ub_dma_rfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rfifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (bus.ub_rdata),
    .pop_i      (pop),
    .pop_dat_o  (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.in_ready    = (state_q == LOAD) && (rem_q != '0);
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = fifo_head;
  assign bus.ub_write_en = ub_we_q;
  assign bus.ub_read_en  = ub_re_q;
  assign bus.ub_addr     = ub_addr_q;
  assign bus.ub_wdata    = ub_wdata_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_ub_dma_mover.sv
// Directed bench for ub_dma_mover: expected UB writes and host words are queued at issue,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ub_dma_mover;
  import ub_dma_mover_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic done;
  int   cyc = 0;

  int checks   = 0;
  int failures = 0;

  ub_dma_mover_if bus ();

  ub_dma_mover dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UB, read latency 1.
  logic [DW-1:0] ub_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ub_write_en) ub_mem[bus.ub_addr] <= bus.ub_wdata;
    if (bus.ub_read_en)  bus.ub_rdata <= ub_mem[bus.ub_addr];
  end

  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_out[$];

  int wr_cnt, rd_cnt, pop_cnt, done_cnt;
  int first_wr, last_wr, first_rd, first_ov, done_cyc, last_pop;
  int done_with_wr, busy_after, max_out, acc_cyc;
  logic          prev_done  = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
    first_wr = -1; last_wr = -1; first_rd = -1; first_ov = -1;
    done_cyc = -1; last_pop = -1; done_with_wr = 0; busy_after = -1; max_out = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ub_write_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (done) done_with_wr = 1;
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected ub_write: addr %0h data %0h, none required", bus.ub_addr, bus.ub_wdata);
        end else begin
          chk("ub_write addr/data", 64'({bus.ub_addr, bus.ub_wdata}), 64'(exp_wr.pop_front()));
        end
      end
      if (bus.ub_read_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.ub_write_en && bus.ub_read_en) begin
        checks++; failures++;
        $display("FAIL ub_write_en and ub_read_en both high: got 1/1 required not both");
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (stall_prev && bus.out_valid) chk("out_data hold", 64'(bus.out_data), 64'(prev_data));
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        last_pop = cyc;
        if (exp_out.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected out word: got %0h, none required", bus.out_data);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(exp_out.pop_front()));
        end
      end
      if (prev_done) busy_after = int'(busy);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
      prev_done  = done;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_done  = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, " cmd_ready"},   64'(bus.cmd_ready),   64'(1));
    chk({tag, " busy"},        64'(busy),            64'(0));
    chk({tag, " done"},        64'(done),            64'(0));
    chk({tag, " ub_write_en"}, 64'(bus.ub_write_en), 64'(0));
    chk({tag, " ub_read_en"},  64'(bus.ub_read_en),  64'(0));
    chk({tag, " ub_addr"},     64'(bus.ub_addr),     64'(0));
    chk({tag, " ub_wdata"},    64'(bus.ub_wdata),    64'(0));
    chk({tag, " in_ready"},    64'(bus.in_ready),    64'(0));
    chk({tag, " out_valid"},   64'(bus.out_valid),   64'(0));
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic do_cmd(input dma_dir_e dir, input logic [AW-1:0] addr, input int len);
    int n = 0;
    bus.cmd_dir   = dir;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LEN_WIDTH'(len);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd accepted", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done pulses"}, 64'(done_cnt), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base);
    int n;
    clear_stats();
    for (int i = 0; i < len; i++) exp_wr.push_back({AW'(addr + AW'(i)), DW'(base + DW'(i))});
    bus.in_valid = 1'b1;
    bus.in_data  = base;
    do_cmd(DMA_LOAD, addr, len);
    for (int i = 0; i < len; i++) begin
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      bus.in_data = base + DW'(i + 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic queue_store(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) exp_out.push_back(base + DW'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = DMA_LOAD;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    clear_stats();
    #1 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // LOAD 0x010 x4: consecutive writes, done with 4th write, idle next cycle.
    run_load(AW'('h010), 4, DW'('hA0));
    wait_done("load4");
    chk("load4 writes",          64'(wr_cnt),              64'(4));
    chk("load4 write span",      64'(last_wr - first_wr),  64'(3));
    chk("load4 done latency",    64'(done_cyc - acc_cyc),  64'(4));
    chk("load4 done with write", 64'(done_with_wr),        64'(1));
    chk("load4 busy after done", 64'(busy_after),          64'(0));
    chk("load4 queue drained",   64'(exp_wr.size()),       64'(0));

    // STORE 0x010 x4 back: order, and one idle cycle from read strobe to out_valid.
    clear_stats();
    queue_store(4, DW'('hA0));
    do_cmd(DMA_STORE, AW'('h010), 4);
    wait_done("store4");
    chk("store4 reads",          64'(rd_cnt),               64'(4));
    chk("store4 words",          64'(pop_cnt),              64'(4));
    chk("store4 first latency",  64'(first_ov - first_rd),  64'(2));
    chk("store4 queue drained",  64'(exp_out.size()),       64'(0));

    // Fill 0x020..0x027, then STORE x8 with out_ready low for cycles 3-10.
    run_load(AW'('h020), 8, DW'('hB0));
    wait_done("load8");
    clear_stats();
    queue_store(8, DW'('hB0));
    do_cmd(DMA_STORE, AW'('h020), 8);
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done("store8");
    chk("store8 reads",           64'(rd_cnt),              64'(8));
    chk("store8 words",           64'(pop_cnt),             64'(8));
    chk("store8 peak outstanding",64'(max_out),             64'(RFIFO_DEPTH));
    chk("store8 done after pop",  64'(done_cyc > last_pop), 64'(1));
    chk("store8 queue drained",   64'(exp_out.size()),      64'(0));

    // Address wrap on LOAD, then read the same words back across the wrap.
    run_load(AW'((1 << AW) - 2), 4, DW'('hC0));
    wait_done("wrap load");
    chk("wrap writes", 64'(wr_cnt), 64'(4));
    clear_stats();
    queue_store(4, DW'('hC0));
    do_cmd(DMA_STORE, AW'((1 << AW) - 2), 4);
    wait_done("wrap store");
    chk("wrap words", 64'(pop_cnt), 64'(4));

    // Zero-length commands.
    clear_stats();
    do_cmd(DMA_LOAD, AW'('h055), 0);
    wait_done("len0 load");
    chk("len0 done latency", 64'(done_cyc - acc_cyc), 64'(0));
    clear_stats();
    do_cmd(DMA_STORE, AW'('h055), 0);
    wait_done("len0 store");
    chk("len0 done latency store", 64'(done_cyc - acc_cyc), 64'(0));
    chk("len0 no writes", 64'(wr_cnt), 64'(0));
    chk("len0 no reads",  64'(rd_cnt), 64'(0));

    // Reset with reads in flight, then a clean STORE x2.
    clear_stats();
    bus.out_ready = 1'b0;
    queue_store(8, DW'('hB0));
    do_cmd(DMA_STORE, AW'('h020), 8);
    begin
      int n = 0;
      while (rd_cnt < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("midstore reads before reset", 64'(rd_cnt), 64'(2));
    #2 rst = 1'b1;
    #1 check_reset_vals("midreset");
    exp_out.delete();
    exp_wr.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
    bus.out_ready = 1'b1;
    queue_store(2, DW'('hA0));
    do_cmd(DMA_STORE, AW'('h010), 2);
    wait_done("post-reset store");
    chk("post-reset reads", 64'(rd_cnt),         64'(2));
    chk("post-reset words", 64'(pop_cnt),        64'(2));
    chk("post-reset queue", 64'(exp_out.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
